// File: rtl/i2s_rx.sv
// Philips I2S slave receiver: oversamples bclk/lrclk/sdata on clk and emits stereo pairs; optional I2S_RX_FRAME_CHECK_EN.
// Latency: 3 clk edges from the first edge that samples bclk high to the sample_valid pulse; no backpressure (pulse is not held).
module i2s_rx #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bclk,
  input  logic              lrclk,
  input  logic              sdata,
  output logic [DATA_W-1:0] left_data,
  output logic [DATA_W-1:0] right_data,
  output logic              sample_valid,
  output logic              frame_err
);

  if (DATA_W < 8 || DATA_W > 32) begin : g_bad_width
    $error("i2s_rx: DATA_W must be within 8..32");
  end

  typedef enum logic [1:0] {
    S_SYNC  = 2'd0,
    S_LEFT  = 2'd1,
    S_RIGHT = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic bclk_s1_q, bclk_s2_q, bclk_dly_q;
  logic lr_s1_q, lr_s2_q;
  logic sd_s1_q, sd_s2_q;

  logic              ws_prev_q, ws_prev_d;
  logic [6:0]        bitcnt_q, bitcnt_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [DATA_W-1:0] word_store;
  logic [DATA_W-1:0] left_hold_q, left_hold_d;
  logic              left_ok_q, left_ok_d;
  logic [DATA_W-1:0] left_q, left_d;
  logic [DATA_W-1:0] right_q, right_d;
  logic              valid_q, valid_d;

  logic rise;
  logic ws_change;
  logic load_left;
  logic right_done;
  logic pair_ok;
  logic frame_bad;
  logic emit;

  // lrclk and sdata share the bclk synchronizer depth so they line up with rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_s1_q  <= 1'b0;
      bclk_s2_q  <= 1'b0;
      bclk_dly_q <= 1'b0;
      lr_s1_q    <= 1'b0;
      lr_s2_q    <= 1'b0;
      sd_s1_q    <= 1'b0;
      sd_s2_q    <= 1'b0;
    end else begin
      bclk_s1_q  <= bclk;
      bclk_s2_q  <= bclk_s1_q;
      bclk_dly_q <= bclk_s2_q;
      lr_s1_q    <= lrclk;
      lr_s2_q    <= lr_s1_q;
      sd_s1_q    <= sdata;
      sd_s2_q    <= sd_s1_q;
    end
  end

  assign rise      = bclk_s2_q & ~bclk_dly_q;
  assign ws_change = rise & (lr_s2_q != ws_prev_q);

  // Accumulator with the current bit merged in; positions past DATA_W are dropped
  always_comb begin
    word_store = word_q;
    for (int i = 0; i < DATA_W; i++) begin
      if (int'(bitcnt_q) == DATA_W - 1 - i) begin
        word_store[i] = sd_s2_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (ws_change) begin
      case (state_q)
        S_SYNC:  state_d = lr_s2_q ? S_RIGHT : S_LEFT;
        S_LEFT:  state_d = S_RIGHT;
        S_RIGHT: state_d = S_LEFT;
        default: state_d = S_SYNC;
      endcase
    end
  end

`ifdef I2S_RX_FRAME_CHECK_EN
  localparam logic [6:0] MIN_CNT = 7'(DATA_W - 1);

  logic [6:0] left_cnt_q, left_cnt_d;
  logic       ferr_q;
`endif

  always_comb begin
    load_left  = ws_change && (state_q == S_LEFT);
    right_done = ws_change && (state_q == S_RIGHT);
    pair_ok    = right_done && left_ok_q;
`ifdef I2S_RX_FRAME_CHECK_EN
    // Counts hold slot length minus one, so MIN_CNT marks a full DATA_W slot
    frame_bad  = pair_ok && ((bitcnt_q != left_cnt_q) ||
                             (bitcnt_q < MIN_CNT) ||
                             (left_cnt_q < MIN_CNT));
`else
    frame_bad  = 1'b0;
`endif
    emit       = pair_ok && !frame_bad;
  end

  always_comb begin
    ws_prev_d   = ws_prev_q;
    bitcnt_d    = bitcnt_q;
    word_d      = word_q;
    left_hold_d = left_hold_q;
    left_ok_d   = left_ok_q;
    left_d      = left_q;
    right_d     = right_q;
    valid_d     = emit;

    if (rise) begin
      if (ws_change) begin
        ws_prev_d = lr_s2_q;
        bitcnt_d  = 7'd0;
        word_d    = '0;
      end else begin
        word_d   = word_store;
        bitcnt_d = (bitcnt_q == 7'd127) ? bitcnt_q : bitcnt_q + 7'd1;
      end
    end

    if (load_left) begin
      left_hold_d = word_store;
      left_ok_d   = 1'b1;
    end
    if (right_done) begin
      left_ok_d = 1'b0;
    end
    if (emit) begin
      left_d  = left_hold_q;
      right_d = word_store;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ws_prev_q   <= 1'b0;
      bitcnt_q    <= 7'd0;
      word_q      <= '0;
      left_hold_q <= '0;
      left_ok_q   <= 1'b0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
    end else begin
      ws_prev_q   <= ws_prev_d;
      bitcnt_q    <= bitcnt_d;
      word_q      <= word_d;
      left_hold_q <= left_hold_d;
      left_ok_q   <= left_ok_d;
      left_q      <= left_d;
      right_q     <= right_d;
      valid_q     <= valid_d;
    end
  end

`ifdef I2S_RX_FRAME_CHECK_EN
  always_comb begin
    left_cnt_d = load_left ? bitcnt_q : left_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_cnt_q <= 7'd0;
      ferr_q     <= 1'b0;
    end else begin
      left_cnt_q <= left_cnt_d;
      ferr_q     <= frame_bad;
    end
  end

  assign frame_err = ferr_q;
`else
  assign frame_err = 1'b0;
`endif

  assign left_data    = left_q;
  assign right_data   = right_q;
  assign sample_valid = valid_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: drives Philips I2S frames into a 16-bit and a 24-bit instance and checks every cycle.
module tb_i2s_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b1;
  logic bclk  = 1'b0;
  logic lrclk = 1'b0;
  logic sdata = 1'b0;

  logic [15:0] l16, r16;
  logic        sv16, fe16;
  logic [23:0] l24, r24;
  logic        sv24, fe24;

  i2s_rx #(.DATA_W(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
    .left_data(l16), .right_data(r16), .sample_valid(sv16), .frame_err(fe16)
  );

  i2s_rx #(.DATA_W(24)) u_dut24 (
    .clk(clk), .rst_n(rst_n), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
    .left_data(l24), .right_data(r24), .sample_valid(sv24), .frame_err(fe24)
  );

  int   vectors     = 0;
  int   miscompares = 0;
  int   pulse_cnt   = 0;
  logic pend        = 1'b0;

  typedef struct {
    logic        e16;
    logic [31:0] l16;
    logic [31:0] r16;
    logic        e24;
    logic [31:0] l24;
    logic [31:0] r24;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] h16l = '0, h16r = '0, h24l = '0, h24r = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, want, $time);
    end
  endtask

  // Word of len bits (MSB first on the wire) as seen by a W-bit receiver
  function automatic logic [31:0] justify(input logic [31:0] w, input int len, input int wd);
    longint unsigned v = 64'(w);
    longint unsigned m = (64'd1 << wd) - 64'd1;
    if (len >= wd) v = v >> (len - wd);
    else           v = v << (wd - len);
    return 32'(v & m);
  endfunction

  function automatic logic bad_frame(input int ll, input int rl, input int wd);
`ifdef I2S_RX_FRAME_CHECK_EN
    return (ll != rl) || (ll < wd) || (rl < wd);
`else
    return 1'b0;
`endif
  endfunction

  task automatic push_frame(input logic [31:0] lw, input int ll, input logic [31:0] rw, input int rl);
    exp_t e;
    e.e16 = bad_frame(ll, rl, 16);
    e.l16 = justify(lw, ll, 16);
    e.r16 = justify(rw, rl, 16);
    e.e24 = bad_frame(ll, rl, 24);
    e.l24 = justify(lw, ll, 24);
    e.r24 = justify(rw, rl, 24);
    expq.push_back(e);
  endtask

  // Pins the frame-A pulse to the cycle after edge 3 (edge 1 = first clk edge seeing bclk high)
  task automatic tcheck();
    repeat (2) @(posedge clk);
    #1 check("lat_edge2_valid", 32'(sv16), 32'd0);
    @(posedge clk);
    #1 check("lat_edge3_valid", 32'(sv16), 32'd1);
    check("A_left16", 32'(l16), 32'h0000A5C3);
    check("A_right16", 32'(r16), 32'h00001234);
    @(posedge clk);
    #1 check("lat_edge4_valid", 32'(sv16), 32'd0);
  endtask

  task automatic drive_bit(input logic lr, input logic sd, input logic tchk);
    @(posedge clk);
    #3;
    bclk  = 1'b0;
    lrclk = lr;
    sdata = sd;
    repeat (3) @(posedge clk);
    #3;
    bclk = 1'b1;
    if (tchk) begin
      fork
        tcheck();
      join_none
    end
    repeat (2) @(posedge clk);
  endtask

  // Philips timing: the slot's first bit period carries the previous word's LSB
  task automatic drive_slot(input logic ch, input logic [31:0] w, input int n, input logic tchk);
    for (int i = 0; i < n; i++) begin
      drive_bit(ch, (i == 0) ? pend : w[n - i], tchk && (i == 0));
    end
    pend = w[0];
  endtask

  task automatic drive_frame(input logic [31:0] lw, input int ll, input logic [31:0] rw, input int rl,
                             input logic tchk);
    push_frame(lw, ll, rw, rl);
    drive_slot(1'b0, lw, ll, tchk);
    drive_slot(1'b1, rw, rl, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      h16l = '0; h16r = '0; h24l = '0; h24r = '0;
      check("reset_left16", 32'(l16), 32'd0);
      check("reset_right24", 32'(r24), 32'd0);
      check("reset_valid", 32'({sv16, sv24, fe16, fe24}), 32'd0);
    end else if (sv16 || fe16 || sv24 || fe24) begin
      if (expq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_event: valid16=%0b err16=%0b valid24=%0b err24=%0b, expected none (t=%0t)",
                 sv16, fe16, sv24, fe24, $time);
      end else begin
        e = expq.pop_front();
        check("valid16", 32'(sv16), 32'(!e.e16));
        check("frame_err16", 32'(fe16), 32'(e.e16));
        check("valid24", 32'(sv24), 32'(!e.e24));
        check("frame_err24", 32'(fe24), 32'(e.e24));
        if (!e.e16) begin h16l = e.l16; h16r = e.r16; end
        if (!e.e24) begin h24l = e.l24; h24r = e.r24; end
        check("pair_left16", 32'(l16), h16l);
        check("pair_right16", 32'(r16), h16r);
        check("pair_left24", 32'(l24), h24l);
        check("pair_right24", 32'(r24), h24r);
      end
      if (sv16) pulse_cnt++;
    end else begin
      check("hold_left16", 32'(l16), h16l);
      check("hold_right16", 32'(r16), h16r);
      check("hold_left24", 32'(l24), h24l);
      check("hold_right24", 32'(r24), h24r);
    end
  end

  int snap;

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("init_left16", 32'(l16), 32'd0);
    check("init_valid16", 32'(sv16), 32'd0);
    check("init_err16", 32'(fe16), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Partial right slot while synchronizing: discarded
    drive_slot(1'b1, 32'h0, 8, 1'b0);
    drive_frame(32'h0000A5C3, 16, 32'h00001234, 16, 1'b0);
    drive_frame(32'hDEADBEEF, 32, 32'h01234567, 32, 1'b1);
    drive_frame(32'h0000FFFF, 16, 32'h00000F0F, 16, 1'b0);
    check("B_left16", 32'(l16), 32'h0000DEAD);
    check("B_right16", 32'(r16), 32'h00000123);
    check("B_left24", 32'(l24), 32'h00DEADBE);
    check("B_right24", 32'(r24), 32'h00012345);
    drive_frame(32'h00008001, 16, 32'h00007FFE, 15, 1'b0);
`ifdef I2S_RX_FRAME_CHECK_EN
    check("C_left24", 32'(l24), 32'h00DEADBE);
`else
    check("C_left24", 32'(l24), 32'h00FFFF00);
    check("C_right24", 32'(r24), 32'h000F0F00);
`endif

    // Reset pulse in the middle of a left slot
    snap = 0;
    fork
      drive_slot(1'b0, 32'h00001111, 16, 1'b0);
      begin
        repeat (35) @(posedge clk);
`ifdef I2S_RX_FRAME_CHECK_EN
        check("D_left16", 32'(l16), 32'h0000FFFF);
        check("D_right16", 32'(r16), 32'h00000F0F);
`else
        check("D_left16", 32'(l16), 32'h00008001);
        check("D_right16", 32'(r16), 32'h0000FFFC);
`endif
        #2 rst_n = 1'b0;
        @(negedge clk);
        #1;
        check("midleft_rst_left16", 32'(l16), 32'd0);
        check("midleft_rst_right16", 32'(r16), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        snap = pulse_cnt;
      end
    join
    drive_slot(1'b1, 32'h00005555, 16, 1'b0);
    drive_frame(32'h00001357, 16, 32'h00002468, 16, 1'b0);
    drive_slot(1'b0, 32'h00003333, 16, 1'b0);
    check("pulses_after_left_reset", 32'(pulse_cnt - snap), 32'd1);
    check("E_left16", 32'(l16), 32'h00001357);

    // Reset in the middle of a right slot, then three complete frames
    fork
      drive_slot(1'b1, 32'h00002222, 16, 1'b0);
      begin
        repeat (40) @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        snap = pulse_cnt;
      end
    join
    drive_slot(1'b1, 32'h00004444, 16, 1'b0);
    drive_frame(32'h0000CAFE, 16, 32'h0000BABE, 16, 1'b0);
    drive_frame(32'h00000001, 16, 32'h00008000, 16, 1'b0);
    drive_frame(32'h00007E57, 16, 32'h0000F00D, 16, 1'b0);
    drive_slot(1'b0, 32'h0, 2, 1'b0);
    repeat (10) @(posedge clk);
    check("pulses_after_right_reset", 32'(pulse_cnt - snap), 32'd3);
    check("H_left16", 32'(l16), 32'h00007E57);
    check("H_right24", 32'(r24), 32'h00F00D00);
    check("pending_expectations", 32'(expq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
